// File: rtl/axi_pkg.sv
// Shared AXI encodings used by the read responder and the pipeline's initiator.
//   RESP_*  : xRESP codes
//   BURST_* : AxBURST codes
//   SIZE_*  : AxSIZE codes (bytes per beat = 2^AxSIZE)
//   ID_*    : transaction IDs for instruction fetch and data load
//   rd_state_e : read responder states
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

  localparam logic [3:0] ID_INSTR = 4'd0;
  localparam logic [3:0] ID_DATA  = 4'd1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_BEAT
  } rd_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI burst address stepper.
//   addr/size/len/burst : current beat address and burst attributes
//   next_addr_c         : address of the following beat
//   wrap_ok_c           : len is a legal WRAP length (2, 4, 8 or 16 beats)
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [63:0] next_addr_c,
  output logic        wrap_ok_c
);

  logic [63:0] step;
  logic [63:0] incr;
  logic [63:0] wrap_mask;

  always_comb begin
    step      = 64'd1 << size;
    incr      = addr + step;
    // boundary = step * (len + 1); step is a power of two so this is a shift
    wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
    wrap_ok_c = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr_c = addr;
    case (burst)
      BURST_INCR: next_addr_c = incr;
      BURST_WRAP: next_addr_c = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:    next_addr_c = addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder with an inline 64-bit word memory.
// One outstanding transaction; programmable first-beat latency; FIXED/INCR/WRAP.
//   clk, rst            : clock, async active-high reset
//   AR*                 : read address channel (ARREADY registered)
//   R*                  : read data channel (all registered)
//   pl_we/pl_idx/pl_wdata : loader write port into the memory
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            ARID,
  input  logic [63:0]           ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [3:0]            RID,
  output logic [63:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  pl_we,
  input  logic [DEPTH_LOG2-1:0] pl_idx,
  input  logic [63:0]           pl_wdata
);

  localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
  localparam logic [63:0] MEM_BYTES = 64'd1 << (DEPTH_LOG2 + 3);
  localparam int unsigned CNT_W     = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [63:0] mem [WORDS];

  rd_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      addr_q;
  logic [7:0]       len_q;
  logic [2:0]       size_q;
  logic [1:0]       burst_q;
  logic             slv_q;
  logic [7:0]       beat_q;

  logic        ar_hs;
  logic        r_hs;
  logic [63:0] sel_addr;
  logic [7:0]  sel_len;
  logic [2:0]  sel_size;
  logic [1:0]  sel_burst;
  logic [63:0] next_addr;
  logic        wrap_ok;
  logic        slv_c;
  logic [63:0] pres_addr;
  logic        pres_slv;
  logic [63:0] offset;
  logic [63:0] word;
  logic [63:0] pres_data;
  logic [1:0]  pres_resp;

  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // Address stepper sees the incoming request in IDLE (legality check)
  // and the latched burst otherwise (next beat address).
  always_comb begin
    sel_addr  = addr_q;
    sel_len   = len_q;
    sel_size  = size_q;
    sel_burst = burst_q;
    if (state == RD_IDLE) begin
      sel_addr  = ARADDR;
      sel_len   = ARLEN;
      sel_size  = ARSIZE;
      sel_burst = ARBURST;
    end
  end

  axi_burst_addr u_burst_addr (
    .addr        (sel_addr),
    .size        (sel_size),
    .len         (sel_len),
    .burst       (sel_burst),
    .next_addr_c (next_addr),
    .wrap_ok_c   (wrap_ok)
  );

  // Data and response for the beat that will be presented at the next edge.
  always_comb begin
    slv_c = (sel_size > SIZE_8B) || (sel_burst == BURST_RSVD) ||
            ((sel_burst == BURST_WRAP) && !wrap_ok);
    pres_addr = addr_q;
    pres_slv  = slv_q;
    case (state)
      RD_IDLE: begin
        pres_addr = ARADDR;
        pres_slv  = slv_c;
      end
      RD_BEAT: pres_addr = next_addr;
      default: ;
    endcase
    // Addresses below BASE_ADDR underflow to huge offsets and fail the range test.
    offset    = pres_addr - BASE_ADDR;
    word      = mem[offset[DEPTH_LOG2+2:3]];
    pres_data = '0;
    pres_resp = RESP_OKAY;
    if (pres_slv) begin
      pres_resp = RESP_SLVERR;
    end else if (offset >= MEM_BYTES) begin
      pres_resp = RESP_DECERR;
    end else begin
      pres_data = word >> {pres_addr[2:0], 3'b000};
    end
  end

  // Loader port; a read in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_wdata;
  end

  // Read FSM with registered channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      cnt     <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      slv_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      case (state)
        RD_IDLE: begin
          ARREADY <= 1'b1;
          if (ar_hs) begin
            ARREADY <= 1'b0;
            RID     <= ARID;
            addr_q  <= ARADDR;
            len_q   <= ARLEN;
            size_q  <= ARSIZE;
            burst_q <= ARBURST;
            slv_q   <= slv_c;
            beat_q  <= '0;
            if (LATENCY <= 1) begin
              state  <= RD_BEAT;
              RVALID <= 1'b1;
              RDATA  <= pres_data;
              RRESP  <= pres_resp;
              RLAST  <= (ARLEN == 8'd0);
            end else begin
              state <= RD_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        RD_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            cnt    <= '0;
            state  <= RD_BEAT;
            RVALID <= 1'b1;
            RDATA  <= pres_data;
            RRESP  <= pres_resp;
            RLAST  <= (len_q == 8'd0);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_BEAT: begin
          if (r_hs) begin
            if (RLAST) begin
              state   <= RD_IDLE;
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= next_addr;
              RDATA  <= pres_data;
              RRESP  <= pres_resp;
              RLAST  <= ((beat_q + 8'd1) == len_q);
            end
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed scenarios followed by
// randomized bursts compared against a queue-based reference model.
module tb_axi_rd_responder;

  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam int unsigned DEPTH     = 12;
  localparam int unsigned LAT       = 2;
  localparam int unsigned WORDS     = 1 << DEPTH;
  localparam logic [63:0] MEM_BYTES = 64'(WORDS) * 64'd8;

  logic             clk;
  logic             rst;
  logic [3:0]       ARID;
  logic [63:0]      ARADDR;
  logic [7:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic             ARVALID;
  logic             ARREADY;
  logic [3:0]       RID;
  logic [63:0]      RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;
  logic             pl_we;
  logic [DEPTH-1:0] pl_idx;
  logic [63:0]      pl_wdata;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic [63:0] ref_mem [WORDS];
  beat_t       exp_q[$];
  bit          rr_q[$];
  int          vectors;
  int          miscompares;

  axi_rd_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ARID     (ARID),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARSIZE   (ARSIZE),
    .ARBURST  (ARBURST),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RID      (RID),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RLAST    (RLAST),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .pl_we    (pl_we),
    .pl_idx   (pl_idx),
    .pl_wdata (pl_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Loader write; called just after a negedge, returns just after the next one.
  task automatic preload(input int idx, input logic [63:0] data);
    pl_we    = 1'b1;
    pl_idx   = DEPTH'(idx);
    pl_wdata = data;
    ref_mem[idx] = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Reference: expected beats straight from the burst rules.
  task automatic build_expect(input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] a;
    logic [63:0] step;
    logic [63:0] span;
    logic [63:0] lo;
    bit          slv;
    beat_t       b;
    exp_q.delete();
    step = 64'd1 << size;
    slv  = (size > 3'd3) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      b.last = (k == int'(len));
      if (slv) begin
        b.data = 64'd0;
        b.resp = 2'b10;
      end else if (a < BASE || a >= BASE + MEM_BYTES) begin
        b.data = 64'd0;
        b.resp = 2'b11;
      end else begin
        b.data = ref_mem[int'((a - BASE) / 64'd8)] >> (8 * int'(a % 64'd8));
        b.resp = 2'b00;
      end
      exp_q.push_back(b);
      if (burst == 2'b01) begin
        a = a + step;
      end else if (burst == 2'b10) begin
        span = step * (64'(len) + 64'd1);
        lo   = a - (a % span);
        a    = lo + ((a - lo + step) % span);
      end
    end
  endtask

  // One complete read transaction; starts and ends just after a negedge.
  // rr_mode 0: RREADY always high, 1: random. rr_q entries override either.
  task automatic run_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int rr_mode, input bit hold_ar);
    int  guard;
    int  hs;
    bit  rr;
    build_expect(addr, len, size, burst);
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len;
    ARSIZE  = size;
    ARBURST = burst;
    ARVALID = 1'b1;
    guard = 0;
    while (ARREADY !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (ARREADY !== 1'b1) begin
      check_val("ar_timeout", 64'(ARREADY), 64'd1);
      ARVALID = 1'b0;
      return;
    end
    @(negedge clk);
    ARVALID = hold_ar;
    ARID    = ~id;
    check_val("arready_drop", 64'(ARREADY), 64'd0);
    guard = 1;
    while (RVALID !== 1'b1 && guard < int'(LAT) + 20) begin
      if (hold_ar) check_val("ar_busy", 64'(ARREADY), 64'd0);
      @(negedge clk);
      guard++;
    end
    check_val("first_beat_latency", 64'(guard), 64'(LAT));
    hs    = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      check_val("rvalid", 64'(RVALID), 64'd1);
      check_val("rid", 64'(RID), 64'(id));
      check_val("rdata", RDATA, exp_q[0].data);
      check_val("rresp", 64'(RRESP), 64'(exp_q[0].resp));
      check_val("rlast", 64'(RLAST), 64'(exp_q[0].last));
      if (hold_ar) check_val("ar_busy", 64'(ARREADY), 64'd0);
      if (rr_q.size() > 0) rr = rr_q.pop_front();
      else if (rr_mode == 0) rr = 1'b1;
      else rr = ($urandom % 4) != 0;
      RREADY = rr;
      if (rr) begin
        void'(exp_q.pop_front());
        hs++;
      end
      @(negedge clk);
      guard++;
    end
    RREADY = 1'b0;
    check_val("handshakes", 64'(hs), 64'(len) + 64'd1);
    check_val("rvalid_clear", 64'(RVALID), 64'd0);
    check_val("rlast_clear", 64'(RLAST), 64'd0);
    check_val("arready_return", 64'(ARREADY), 64'd1);
    if (hold_ar) begin
      ARVALID = 1'b0;
      repeat (3) @(negedge clk);
      check_val("no_queued_req", 64'(RVALID), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    int          guard;
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    ARID     = '0;
    ARADDR   = '0;
    ARLEN    = '0;
    ARSIZE   = '0;
    ARBURST  = '0;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    pl_we    = 1'b0;
    pl_idx   = '0;
    pl_wdata = '0;

    @(negedge clk);
    for (int i = 0; i < int'(WORDS); i++) preload(i, {$urandom, $urandom});

    check_val("rst_arready", 64'(ARREADY), 64'd0);
    check_val("rst_rvalid", 64'(RVALID), 64'd0);
    check_val("rst_rlast", 64'(RLAST), 64'd0);
    check_val("rst_rid", 64'(RID), 64'd0);
    check_val("rst_rdata", RDATA, 64'd0);
    check_val("rst_rresp", 64'(RRESP), 64'd0);

    rst = 1'b0;
    @(negedge clk);
    check_val("arready_after_rst", 64'(ARREADY), 64'd1);

    // 4-byte fetch of the upper half of word 0
    preload(0, 64'h1122_3344_5566_7788);
    run_burst(4'd0, 64'h8000_0004, 8'd0, 3'd2, 2'b01, 0, 1'b0);

    // INCR over four words, back-to-back
    preload(0, 64'd10);
    preload(1, 64'd20);
    preload(2, 64'd30);
    preload(3, 64'd40);
    run_burst(4'd1, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 0, 1'b0);

    // WRAP from word 2: order 2,3,0,1
    run_burst(4'd0, 64'h8000_0010, 8'd3, 3'd3, 2'b10, 0, 1'b0);

    // Decode error below base, reserved burst type
    run_burst(4'd0, 64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0, 1'b0);
    run_burst(4'd1, 64'h8000_0000, 8'd2, 3'd3, 2'b11, 0, 1'b0);

    // Backpressure pattern with a second request held during the burst
    rr_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_burst(4'd1, 64'h8000_0008, 8'd1, 3'd3, 2'b01, 0, 1'b1);

    // Reset in the middle of a 4-beat burst
    ARID = 4'd1; ARADDR = BASE; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    guard = 0;
    while (ARREADY !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    ARVALID = 1'b0;
    guard = 0;
    while (RVALID !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    RREADY = 1'b1;
    @(negedge clk);
    check_val("midburst_rvalid", 64'(RVALID), 64'd1);
    check_val("midburst_rdata", RDATA, 64'd20);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_rvalid", 64'(RVALID), 64'd0);
    check_val("async_rst_arready", 64'(ARREADY), 64'd0);
    check_val("async_rst_rlast", 64'(RLAST), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    RREADY = 1'b0;
    @(negedge clk);
    check_val("post_rst_arready", 64'(ARREADY), 64'd1);
    check_val("post_rst_rvalid", 64'(RVALID), 64'd0);
    run_burst(4'd0, BASE + 64'd8, 8'd1, 3'd3, 2'b01, 0, 1'b0);

    // Randomized bursts
    for (int n = 0; n < 60; n++) begin
      if (($urandom % 3) == 0) preload(int'($urandom % WORDS), {$urandom, $urandom});
      case ($urandom % 10)
        0:       a = {$urandom, $urandom};
        1:       a = BASE - 64'(8 * (1 + $urandom % 4)) + 64'($urandom % 8);
        2:       a = BASE + MEM_BYTES - 64'(8 * (1 + $urandom % 4)) + 64'($urandom % 8);
        default: a = BASE + (64'($urandom) % MEM_BYTES);
      endcase
      case ($urandom % 6)
        0:       l = 8'd0;
        1:       l = 8'd1;
        2:       l = 8'd3;
        3:       l = 8'd7;
        4:       l = 8'd15;
        default: l = 8'($urandom % 20);
      endcase
      s = (($urandom % 10) == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
      run_burst(4'($urandom), a, l, s, 2'($urandom), 1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
